// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one-deep buffer between PC register and decode.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] pc,
    output logic [31:0] nextPc,
    output logic        pcLoad,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        instFault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] inst_q, inst_pc_q;
    logic        fault_q;
    logic        req, load;
    logic [31:0] npc;
    logic        cap_mem, cap_fault, drop_buf;
    logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        load      = 1'b0;
        npc       = '0;
        cap_mem   = 1'b0;
        cap_fault = 1'b0;
        drop_buf  = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (misaligned) begin
                    // No request went out, so a redirect needs no DISCARD.
                    state_nxt = redirect ? REQ : HOLD;
                    cap_fault = !redirect;
                end else begin
                    req = 1'b1;
                    if (imemValid) begin
                        if (!redirect) begin
                            cap_mem   = 1'b1;
                            load      = 1'b1;
                            npc       = pc + PC_STEP;
                            state_nxt = HOLD;
                        end
                    end else if (redirect) begin
                        state_nxt = DISCARD;
                    end
                end
            end
            HOLD: begin
                if (instReady || redirect) begin
                    state_nxt = REQ;
                    drop_buf  = 1'b1;
                end
            end
            DISCARD: if (imemValid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            load = 1'b1;
            npc  = redirectPc;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cap_mem) begin
                inst_q    <= imemRdata;
                inst_pc_q <= pc;
                fault_q   <= 1'b0;
            end else if (cap_fault) begin
                inst_q    <= NOP_INST;
                inst_pc_q <= pc;
                fault_q   <= 1'b1;
            end else if (drop_buf) begin
                inst_q  <= NOP_INST;
                fault_q <= 1'b0;
            end
        end
    end

    assign imemReq   = req & ~areset;
    assign pcLoad    = load & ~areset;
    assign nextPc    = areset ? 32'd0 : npc;
    assign imemAddr  = {pc[31:2], 2'b00};
    assign instValid = (state == HOLD);
    assign inst      = inst_q;
    assign instPc    = inst_pc_q;
    assign instFault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a PC/memory/stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        pcLoad;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instFault;

    fetch_unit dut (
        .clk(clk), .areset(areset), .pc(pc), .nextPc(nextPc), .pcLoad(pcLoad),
        .redirect(redirect), .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemValid(imemValid), .imemRdata(imemRdata), .instValid(instValid),
        .instReady(instReady), .inst(inst), .instPc(instPc), .instFault(instFault)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        pending;
    int          mcnt;
    int          lat;
    logic [31:0] maddr;
    logic        s_req, s_load, s_valid, s_fault;
    logic [31:0] s_addr, s_npc, s_inst, s_ipc;
    logic [31:0] exp_pc;
    bit          sb_en;
    int          deliveries;
    int          d0;
    logic        any_req, hit;
    logic [31:0] req_addr, r;

    // Memory contents: known word at 0, address hash elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'd0) return 32'h00500093;
        return (w * 32'h9E3779B1) ^ 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs, score deliveries, then update PC and memory.
    task automatic tick(input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        redirect   = rd;
        redirectPc = rpc;
        instReady  = rdy;
        if (!pending && imemReq) begin
            pending = 1'b1;
            maddr   = imemAddr;
            mcnt    = lat;
        end
        if (pending && mcnt == 0) begin
            imemValid = 1'b1;
            imemRdata = memf(maddr);
        end else begin
            imemValid = 1'b0;
            imemRdata = $urandom;
        end
        #1;
        s_req = imemReq;   s_addr = imemAddr; s_load = pcLoad; s_npc = nextPc;
        s_valid = instValid; s_inst = inst; s_ipc = instPc; s_fault = instFault;
        if (s_valid && rdy) begin
            deliveries++;
            if (sb_en) begin
                chk("sb_pc", s_ipc, exp_pc);
                chk("sb_inst", s_inst, memf(s_ipc));
                chk("sb_fault", {31'd0, s_fault}, 32'd0);
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (rd) exp_pc = rpc;
        if (sb_en) chk("req_while_valid", {31'd0, s_valid & s_req}, 32'd0);
        @(posedge clk);
        #1;
        if (s_load) pc = s_npc;
        if (imemValid) pending = 1'b0;
        else if (pending) mcnt--;
    endtask

    task automatic wait_for(input int kind, input string tag, input logic rdy);
        logic h;
        h = 1'b0;
        for (int i = 0; i < 30 && !h; i++) begin
            tick(1'b0, 32'd0, rdy);
            h = (kind == 0) ? s_load : (kind == 1) ? s_valid : s_req;
        end
        chk({tag, "_seen"}, {31'd0, h}, 32'd1);
    endtask

    initial begin
        pending = 1'b0; mcnt = 0; lat = 1; maddr = '0;
        sb_en = 1'b1; exp_pc = '0; deliveries = 0;
        areset = 1'b1; pc = '0; redirect = 1'b1; redirectPc = 32'h123;
        instReady = 1'b0; imemValid = 1'b0; imemRdata = '0;

        @(posedge clk); #1;
        chk("rst_valid", {31'd0, instValid}, 32'd0);
        chk("rst_inst", inst, 32'h00000013);
        chk("rst_pc", instPc, 32'd0);
        chk("rst_fault", {31'd0, instFault}, 32'd0);
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_load", {31'd0, pcLoad}, 32'd0);
        chk("rst_npc", nextPc, 32'd0);
        redirect = 1'b0;
        areset = 1'b0;

        // Basic fetch, 1-cycle memory latency
        tick(0, 0, 1); chk("idle_req", {31'd0, s_req}, 32'd0);
        tick(0, 0, 1); chk("t1_req", {31'd0, s_req}, 32'd1); chk("t1_addr", s_addr, 32'd0);
        chk("t1_noload", {31'd0, s_load}, 32'd0);
        tick(0, 0, 1); chk("t1_load", {31'd0, s_load}, 32'd1); chk("t1_npc", s_npc, 32'd4);
        tick(0, 0, 1); chk("t1_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_inst", s_inst, 32'h00500093); chk("t1_ipc", s_ipc, 32'd0);
        tick(0, 0, 1); chk("t2_req", {31'd0, s_req}, 32'd1); chk("t2_addr", s_addr, 32'd4);

        // Back-pressure in HOLD
        tick(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0);
            chk("hold_valid", {31'd0, s_valid}, 32'd1);
            chk("hold_inst", s_inst, memf(32'd4));
            chk("hold_ipc", s_ipc, 32'd4);
            chk("hold_req", {31'd0, s_req}, 32'd0);
            chk("hold_load", {31'd0, s_load}, 32'd0);
        end
        tick(0, 0, 1);

        // Redirect while REQ waits on a slow response
        lat = 3;
        tick(0, 0, 1); chk("slow_req", {31'd0, s_req}, 32'd1);
        tick(1, 32'h100, 1);
        chk("redir_load", {31'd0, s_load}, 32'd1); chk("redir_npc", s_npc, 32'h100);
        tick(0, 0, 1); chk("disc_valid0", {31'd0, s_valid}, 32'd0);
        lat = 1;
        tick(0, 0, 1); chk("disc_valid1", {31'd0, s_valid}, 32'd0);
        chk("disc_noload", {31'd0, s_load}, 32'd0);
        tick(0, 0, 1); chk("redir_req", {31'd0, s_req}, 32'd1); chk("redir_addr", s_addr, 32'h100);
        tick(0, 0, 1);

        // Redirect in HOLD with instReady in the same cycle
        d0 = deliveries;
        tick(1, 32'h200, 1);
        chk("hr_valid", {31'd0, s_valid}, 32'd1); chk("hr_ipc", s_ipc, 32'h100);
        chk("hr_count", deliveries, d0 + 1);
        chk("hr_npc", s_npc, 32'h200);
        tick(0, 0, 1);
        chk("hr_drop", {31'd0, s_valid}, 32'd0);
        chk("hr_req", {31'd0, s_req}, 32'd1); chk("hr_addr", s_addr, 32'h200);

        // PC wrap
        tick(1, 32'hFFFFFFFC, 1);
        wait_for(0, "wrap_load", 1'b1);
        chk("wrap_addr", s_addr, 32'hFFFFFFFC);
        chk("wrap_npc", s_npc, 32'd0);
        wait_for(1, "wrap_valid", 1'b1);

        // Misaligned PC
        sb_en = 1'b0;
        tick(1, 32'h2, 0);
        any_req = 1'b0; hit = 1'b0; req_addr = 32'hFFFFFFFF;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(0, 0, 0);
            any_req = any_req | s_req;
            if (s_req) req_addr = s_addr;
            hit = s_valid;
        end
        chk("mis_valid", {31'd0, hit}, 32'd1);
        chk("mis_ipc", s_ipc, 32'd2);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_noreq", {31'd0, any_req}, 32'd0);
        chk("mis_fault", {31'd0, s_fault}, 32'd1);
        chk("mis_inst", s_inst, 32'h00000013);
`else
        chk("mis_addr", req_addr, 32'd0);
        chk("mis_fault", {31'd0, s_fault}, 32'd0);
        chk("mis_inst", s_inst, 32'h00500093);
`endif
        tick(1, 32'h40, 1);
        tick(0, 0, 1);
        chk("fault_clear", {31'd0, s_fault}, 32'd0);
        sb_en = 1'b1;

        // Randomized traffic against the stream model
        d0 = deliveries;
        for (int i = 0; i < 800; i++) begin
            lat = $urandom_range(0, 3);
            r = $urandom;
            r[1:0] = 2'b00;
            tick(($urandom_range(0, 7) == 0), r, 1'($urandom_range(0, 1)));
        end
        chk("rand_progress", {31'd0, deliveries > d0 + 50}, 32'd1);

        // Reset mid-operation
        #2;
        areset = 1'b1;
        #1;
        chk("mrst_req", {31'd0, imemReq}, 32'd0);
        chk("mrst_valid", {31'd0, instValid}, 32'd0);
        chk("mrst_load", {31'd0, pcLoad}, 32'd0);
        chk("mrst_inst", inst, 32'h00000013);
        pending = 1'b0; imemValid = 1'b0; redirect = 1'b0; pc = '0; exp_pc = '0; lat = 2;
        @(posedge clk); #1;
        areset = 1'b0;
        wait_for(1, "post_rst_valid", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the program counter register.
- Consumes the current `pc` value and issues an instruction-memory read.
- Buffers the returned word and hands it to decode over a valid/ready handshake.
- Drives `nextPc`/`pcLoad` back into the PC register: sequential advance, or a redirect target from execute.

Parameters:
- PC_STEP, 4, byte increment applied to `pc` after each accepted fetch.
- NOP_INST, 32'h00000013, word presented on `inst` when no real instruction is held (RISC-V `addi x0,x0,0`).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- areset  in  1  asynchronous, active-high reset.
- pc  in  32  current PC from the PC register.
- nextPc  out  32  next PC value to the PC register (combinational).
- pcLoad  out  1  load strobe to the PC register (combinational).
- redirect  in  1  single-cycle flush/redirect request from execute.
- redirectPc  in  32  redirect target; valid when `redirect`=1.
- imemReq  out  1  read request to instruction memory.
- imemAddr  out  32  read address (combinational).
- imemValid  in  1  read data valid.
- imemRdata  in  32  read data.
- instValid  out  1  buffered instruction valid to decode.
- instReady  in  1  decode accepts the instruction.
- inst  out  32  buffered instruction.
- instPc  out  32  PC of the buffered instruction.
- instFault  out  1  misaligned-fetch flag (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - `areset` is asynchronous and active-high. While high: state=IDLE, `instValid`=0, `inst`=NOP_INST, `instPc`=0, `instFault`=0.
  - Combinational outputs are 0 during reset (`imemReq`, `pcLoad`, `nextPc`).
- States: IDLE, REQ, HOLD, DISCARD.
- IDLE:
  - Entered only from reset.
  - No request issued.
  - Next cycle → REQ (or → REQ with `pcLoad` if `redirect`).
- REQ:
  - `imemReq`=1, `imemAddr`={pc[31:2],2'b00}.
  - `imemReq` held until `imemValid` is sampled 1. A same-cycle response is legal.
  - On `imemValid`=1: capture `inst`=`imemRdata`, `instPc`=`pc`; pulse `pcLoad`=1 with `nextPc`=`pc`+PC_STEP (mod 2^32, wraps to 0); → HOLD.
- HOLD:
  - `instValid`=1, `imemReq`=0, buffer stable.
  - On `instReady`=1 the transfer completes; → REQ next cycle, which uses the already-updated `pc`.
  - Throughput is at most 1 instruction per 2 cycles.
- DISCARD:
  - `imemReq`=0. Waits for the outstanding response.
  - On `imemValid`, drop the data; → REQ.
- Redirect (highest priority, any state except reset):
  - `pcLoad`=1, `nextPc`=`redirectPc` in that cycle. This overrides the sequential update.
  - IDLE → REQ.
  - REQ with `imemValid`=1 → response dropped; → REQ.
  - REQ with `imemValid`=0 → DISCARD.
  - HOLD: buffer invalidated, `instValid`=0 next cycle; → REQ. If `instReady`=1 in the same cycle, the transfer still counts as completed.
  - DISCARD: stay in DISCARD; only the single outstanding response is dropped.
- `imemValid` outside REQ/DISCARD is ignored.
- Reset mid-operation aborts any request immediately. Memory must tolerate a dropped request.
- Exactly one outstanding memory request at any time.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In REQ, if `pc[1:0]`≠0, no memory request is issued (`imemReq`=0).
  - Next cycle → HOLD with `inst`=NOP_INST, `instPc`=`pc`, `instFault`=1.
  - `pcLoad` is not pulsed; the PC is changed only by a redirect.
  - `instFault` clears when the buffer is consumed or invalidated.
- Undefined: `pc[1:0]` is ignored (address forced word-aligned) and `instFault` is tied to 0.

Test Plan:
- Reset, then pc=0, memory returns 32'h00500093 one cycle after request, instReady=1 → `instValid` with `inst`=00500093, `instPc`=0; `pcLoad` pulse with `nextPc`=4; second request at address 4.
- Hold instReady=0 for 5 cycles while in HOLD → `instValid`, `inst` and `instPc` stable; `imemReq`=0; no `pcLoad` pulse.
- Redirect to 32'h00000100 while REQ is waiting (memory latency 3) → `pcLoad`/`nextPc`=100 that cycle; late response dropped (no `instValid`); next request at 100.
- Redirect in HOLD with instReady=1 in the same cycle → one transfer counted; `instValid` drops; next fetch at `redirectPc`.
- pc=32'hFFFFFFFC fetch → `nextPc`=0 (wrap).
- With FETCH_ALIGN_CHECK_EN, pc=32'h00000002 → no `imemReq`; `instValid` with `instFault`=1, `inst`=00000013. Without the macro → request at address 0, `instFault`=0.
